// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: valid/ready register chain with bubble collapsing, flush and occupancy count
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int CNT_W = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);
    localparam logic [STAGES-1:0] ONES = '1;
    logic [STAGES-1:0] v_q, v_d, adv, up_v;
    logic [STAGES-1:0][WIDTH-1:0] d_q, d_d, up_d;
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v_q[i-1];
            up_d[i] = d_q[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            adv[i] = out_ready | ((v_q >> i) != (ONES >> i));
            v_d[i] = flush ? 1'b0 : adv[i] ? up_v[i] : v_q[i];
            d_d[i] = flush ? RESET_VAL : (adv[i] & up_v[i]) ? up_d[i] : d_q[i];
        end
    end
    assign in_ready  = adv[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign occupancy = CNT_W'($countones(v_q));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            d_q <= {STAGES{RESET_VAL}};
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: two chains (2 and 3 stages) checked each cycle against an item-position model
module tb_pipe_reg_chain;
    localparam int W = 32;
    localparam logic [W-1:0] RV = 32'hC0DE_0000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic [1:0] iv, ordy;
    logic [1:0][W-1:0] id;
    wire  [1:0] ir, ov;
    wire  [1:0][W-1:0] od;
    wire  [1:0][1:0] occ;
    int n_vec = 0;
    int n_err = 0;
    int mcnt [2];
    int mpos [2][4];
    logic [W-1:0] mdat [2][4];
    logic [W-1:0] mlast [2];
    bit held [2];
    logic [1:0] pend;
    logic [W-1:0] pd [2];

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(W), .STAGES(2), .RESET_VAL(RV)) u_s2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ[0])
    );
    pipe_reg_chain #(.WIDTH(W), .STAGES(3), .RESET_VAL(RV)) u_s3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ[1])
    );

    // a producer stalled by in_ready=0 must keep in_valid and in_data steady
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (pend[k])
                    assert (iv[k] && id[k] == pd[k]) else $error("producer rule violated on chain %0d", k);
                pend[k] <= iv[k] & ~ir[k];
                pd[k] <= id[k];
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int stg(input int k);
        return k == 0 ? 2 : 3;
    endfunction

    // slot limit left free at the input once every item has moved as far as it can
    function automatic int mlim(input int k);
        int lim = ordy[k] ? stg(k) + 1 : stg(k);
        for (int i = 0; i < mcnt[k]; i++)
            lim = (mpos[k][i] + 1 < lim - 1) ? mpos[k][i] + 1 : lim - 1;
        return lim;
    endfunction

    function automatic bit exp_ir(input int k);
        return !flush && mlim(k) >= 1;
    endfunction

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mlast[k] = RV;
            held[k] = 0;
        end
    endtask

    task automatic mstep(input int k);
        int s, lim, n, p;
        int tp [4];
        logic [W-1:0] td [4];
        bit acc;
        s = stg(k);
        acc = iv[k] && exp_ir(k);
        if (flush) begin
            mcnt[k] = 0;
            mlast[k] = RV;
            return;
        end
        lim = ordy[k] ? s + 1 : s;
        n = 0;
        for (int i = 0; i < mcnt[k]; i++) begin
            p = (mpos[k][i] + 1 < lim - 1) ? mpos[k][i] + 1 : lim - 1;
            lim = p;
            if (p < s) begin
                tp[n] = p;
                td[n] = mdat[k][i];
                n++;
                if (p == s - 1) mlast[k] = mdat[k][i];
            end
        end
        if (acc) begin
            tp[n] = 0;
            td[n] = id[k];
            n++;
            if (s == 1) mlast[k] = id[k];
        end
        mcnt[k] = n;
        for (int i = 0; i < n; i++) begin
            mpos[k][i] = tp[i];
            mdat[k][i] = td[i];
        end
    endtask

    task automatic eval();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("s%0d_out_valid", stg(k)), W'(ov[k]), W'(mcnt[k] > 0 && mpos[k][0] == stg(k) - 1));
            chk($sformatf("s%0d_out_data", stg(k)), od[k], mlast[k]);
            chk($sformatf("s%0d_occupancy", stg(k)), W'(occ[k]), W'(mcnt[k]));
            chk($sformatf("s%0d_in_ready", stg(k)), W'(ir[k]), W'(exp_ir(k)));
        end
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) mstep(k);
        for (int k = 0; k < 2; k++) held[k] = iv[k] && !ir[k];
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        iv = '0;
        id = '0;
        ordy = 2'b11;
        mreset();
        @(negedge clk);
        @(negedge clk);
        eval();
        reset = 1'b0;
        step();
        iv[0] = 1'b1;
        id[0] = 32'hA5A5_0001;
        eval();
        chk("fill_occ_c0", W'(occ[0]), 0);
        chk("fill_ir_c0", W'(ir[0]), 1);
        step();
        iv[0] = 1'b0;
        eval();
        chk("fill_occ_c1", W'(occ[0]), 1);
        chk("fill_ov_c1", W'(ov[0]), 0);
        step();
        eval();
        chk("fill_ov_c2", W'(ov[0]), 1);
        chk("fill_od_c2", od[0], 32'hA5A5_0001);
        chk("fill_occ_c2", W'(occ[0]), 1);
        step();
        eval();
        chk("fill_occ_c3", W'(occ[0]), 0);
        step();
        for (int i = 0; i < 18; i++) begin
            iv[0] = i < 16;
            id[0] = W'(32'h10 + i);
            eval();
            if (i < 16) chk("stream_ir", W'(ir[0]), 1);
            if (i >= 2) begin
                chk("stream_ov", W'(ov[0]), 1);
                chk("stream_od", od[0], W'(32'h10 + i - 2));
            end
            step();
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        id[0] = 32'h1;
        eval();
        chk("bp_ir_1", W'(ir[0]), 1);
        step();
        id[0] = 32'h2;
        eval();
        chk("bp_ir_2", W'(ir[0]), 1);
        step();
        id[0] = 32'h3;
        eval();
        chk("bp_ir_full", W'(ir[0]), 0);
        chk("bp_occ_full", W'(occ[0]), 2);
        step();
        eval();
        chk("bp_ir_hold", W'(ir[0]), 0);
        step();
        ordy[0] = 1'b1;
        eval();
        chk("bp_ir_release", W'(ir[0]), 1);
        chk("bp_od_1", od[0], 32'h1);
        step();
        iv[0] = 1'b0;
        eval();
        chk("bp_od_2", od[0], 32'h2);
        step();
        eval();
        chk("bp_od_3", od[0], 32'h3);
        step();
        eval();
        chk("bp_occ_empty", W'(occ[0]), 0);
        step();
        ordy[1] = 1'b0;
        iv[1] = 1'b1;
        id[1] = 32'h7;
        eval();
        step();
        iv[1] = 1'b0;
        repeat (3) begin
            eval();
            step();
        end
        iv[1] = 1'b1;
        id[1] = 32'h8;
        eval();
        chk("bc_ir_8", W'(ir[1]), 1);
        step();
        id[1] = 32'h9;
        eval();
        chk("bc_ir_9", W'(ir[1]), 1);
        step();
        iv[1] = 1'b0;
        eval();
        chk("bc_occ_full", W'(occ[1]), 3);
        chk("bc_ir_full", W'(ir[1]), 0);
        chk("bc_od_7", od[1], 32'h7);
        step();
        ordy[1] = 1'b1;
        repeat (4) begin
            eval();
            step();
        end
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        id[0] = 32'h11;
        eval();
        step();
        id[0] = 32'h22;
        eval();
        step();
        id[0] = 32'hDEAD;
        ordy[0] = 1'b1;
        flush = 1'b1;
        eval();
        chk("fl_ir", W'(ir[0]), 0);
        chk("fl_occ_pre", W'(occ[0]), 2);
        step();
        flush = 1'b0;
        eval();
        chk("fl_occ", W'(occ[0]), 0);
        chk("fl_ov", W'(ov[0]), 0);
        chk("fl_od", od[0], RV);
        step();
        iv[0] = 1'b0;
        eval();
        step();
        eval();
        chk("fl_dead_later", od[0], 32'hDEAD);
        step();
        eval();
        step();
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        id[0] = 32'h31;
        eval();
        step();
        id[0] = 32'h32;
        eval();
        step();
        iv[0] = 1'b0;
        eval();
        chk("ar_occ_pre", W'(occ[0]), 2);
        #2 reset = 1'b1;
        #1;
        chk("ar_ov", W'(ov[0]), 0);
        chk("ar_occ", W'(occ[0]), 0);
        chk("ar_od", od[0], RV);
        mreset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        id[0] = 32'h55;
        eval();
        step();
        iv[0] = 1'b0;
        eval();
        chk("ar_lat_c1", W'(ov[0]), 0);
        step();
        eval();
        chk("ar_lat_c2", W'(ov[0]), 1);
        chk("ar_od_c2", od[0], 32'h55);
        step();
        repeat (400) begin
            for (int k = 0; k < 2; k++) begin
                if (!held[k]) begin
                    iv[k] = $urandom_range(0, 9) < 7;
                    id[k] = $urandom;
                end
                ordy[k] = $urandom_range(0, 9) < 6;
            end
            flush = $urandom_range(0, 39) == 0;
            eval();
            step();
        end
        flush = 1'b0;
        ordy = 2'b11;
        repeat (5) begin
            for (int k = 0; k < 2; k++) if (!held[k]) iv[k] = 1'b0;
            eval();
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
